// File: rtl/freq_div_gen.sv
// Programmable clock-enable generator: one-cycle Tick_o every D clocks and a square wave of
// period 2*D, with D taken from a parametrised divisor table indexed by Sel_i.
module freq_div_gen #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 8,
    parameter logic [CNT_W*(2**SEL_W)-1:0] DIV_TABLE =
        {8'd24, 8'd28, 8'd32, 8'd39, 8'd49, 8'd66, 8'd99, 8'd165}
) (
    input  logic             Clk_i,
    input  logic             Rst_n_i,
    input  logic             En_i,
    input  logic             Restart_i,
    input  logic             Mode_i,
    input  logic [SEL_W-1:0] Sel_i,
    output logic             Tick_o,
    output logic             Sq_o,
    output logic [CNT_W-1:0] Div_o,
    output logic             Done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] sel_div;

    // A zero table entry would stall the counter, so it is treated as divide-by-one.
    function automatic logic [CNT_W-1:0] table_div(input logic [SEL_W-1:0] s);
        logic [CNT_W-1:0] e;
        e = DIV_TABLE[s*CNT_W +: CNT_W];
        return (e == '0) ? CNT_W'(1) : e;
    endfunction

    assign sel_div = table_div(Sel_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        sq_d    = sq_q;
        done_d  = done_q;
        mode_d  = mode_q;
        if (Restart_i && En_i) begin
            state_d = RUN;
            cnt_d   = sel_div - CNT_W'(1);
            div_d   = sel_div;
            sq_d    = 1'b0;
            done_d  = 1'b0;
            mode_d  = Mode_i;
        end else if (!En_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            sq_d    = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    cnt_d   = sel_div - CNT_W'(1);
                    div_d   = sel_div;
                    mode_d  = Mode_i;
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        tick_d = 1'b1;
                        sq_d   = ~sq_q;
                        // Sel_i is only looked at here, so divisor switches land on period boundaries.
                        if (mode_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = sel_div - CNT_W'(1);
                            div_d = sel_div;
                        end
                    end
                end
                DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= table_div('0);
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    assign Tick_o = tick_q;
    assign Sq_o   = sq_q;
    assign Div_o  = div_q;
    assign Done_o = done_q;

endmodule

// File: tb/tb_freq_div_gen.sv
// Directed bench for freq_div_gen: default table instance plus one with entries 0 and 1.
module tb_freq_div_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, restart, mode;
    logic [2:0] sel;
    logic       tick, sq, done;
    logic [7:0] div;

    logic       en2, restart2, mode2;
    logic [2:0] sel2;
    logic       tick2, sq2, done2;
    logic [7:0] div2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    freq_div_gen dut (
        .Clk_i(clk), .Rst_n_i(rst_n), .En_i(en), .Restart_i(restart), .Mode_i(mode),
        .Sel_i(sel), .Tick_o(tick), .Sq_o(sq), .Div_o(div), .Done_o(done)
    );

    freq_div_gen #(
        .DIV_TABLE({8'd24, 8'd28, 8'd32, 8'd39, 8'd49, 8'd66, 8'd1, 8'd0})
    ) dut2 (
        .Clk_i(clk), .Rst_n_i(rst_n), .En_i(en2), .Restart_i(restart2), .Mode_i(mode2),
        .Sel_i(sel2), .Tick_o(tick2), .Sq_o(sq2), .Div_o(div2), .Done_o(done2)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Returns the number of edges until Tick_o is seen high (bounded by lim).
    task automatic wait_tick(input int lim, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < lim);
    endtask

    initial begin
        int n;
        int cnt_ticks;
        rst_n = 1'b0; en = 1'b0; restart = 1'b0; mode = 1'b0; sel = 3'd0;
        en2 = 1'b0; restart2 = 1'b0; mode2 = 1'b0; sel2 = 3'd0;
        steps(2);

        // Reset values
        check_eq("rst_tick", tick, 0);
        check_eq("rst_sq", sq, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_div", div, 165);
        check_eq("rst_div2", div2, 1);

        // 1: Sel=0 continuous, D=165
        rst_n = 1'b1; en = 1'b1; sel = 3'd0;
        step();
        check_eq("t1_load_tick", tick, 0);
        check_eq("t1_div", div, 165);
        wait_tick(200, n);
        check_eq("t1_gap1", n, 165);
        check_eq("t1_sq1", sq, 1);
        step();
        check_eq("t1_tick_width", tick, 0);
        wait_tick(200, n);
        check_eq("t1_gap2", n, 164);
        check_eq("t1_sq2", sq, 0);

        // 2: Sel=7 continuous, then switch to Sel=0 mid-period
        en = 1'b0; step();
        check_eq("t2_idle_tick", tick, 0);
        en = 1'b1; sel = 3'd7; step();
        check_eq("t2_div", div, 24);
        wait_tick(60, n);
        check_eq("t2_gap1", n, 24);
        wait_tick(60, n);
        check_eq("t2_gap2", n, 24);
        steps(5);
        sel = 3'd0;
        step();
        check_eq("t2_div_hold", div, 24);
        wait_tick(60, n);
        check_eq("t2_gap_switch", n, 18);
        check_eq("t2_div_new", div, 165);
        wait_tick(200, n);
        check_eq("t2_gap_165", n, 165);

        // 3: one-shot Sel=5 (D=32), then restart
        en = 1'b0; step();
        mode = 1'b1; sel = 3'd5; en = 1'b1; step();
        wait_tick(60, n);
        check_eq("t3_gap", n, 32);
        check_eq("t3_done", done, 1);
        check_eq("t3_sq", sq, 1);
        cnt_ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick) cnt_ticks++;
        end
        check_eq("t3_no_more_ticks", cnt_ticks, 0);
        check_eq("t3_done_hold", done, 1);
        check_eq("t3_sq_hold", sq, 1);
        restart = 1'b1; step(); restart = 1'b0;
        check_eq("t3_rs_done", done, 0);
        check_eq("t3_rs_sq", sq, 0);
        check_eq("t3_rs_tick", tick, 0);
        wait_tick(60, n);
        check_eq("t3_rs_gap", n, 32);

        // 4: restart at cnt=10 and at cnt=0 during Sel=3 (D=49)
        en = 1'b0; step();
        mode = 1'b0; sel = 3'd3; en = 1'b1; step();
        wait_tick(80, n);
        check_eq("t4_gap", n, 49);
        steps(38);
        restart = 1'b1; step(); restart = 1'b0;
        check_eq("t4_rs_tick", tick, 0);
        check_eq("t4_rs_sq", sq, 0);
        wait_tick(80, n);
        check_eq("t4_rs_gap", n, 49);
        steps(48);
        restart = 1'b1; step(); restart = 1'b0;
        check_eq("t4_rs0_tick", tick, 0);
        wait_tick(80, n);
        check_eq("t4_rs0_gap", n, 49);
        check_eq("t4_sq", sq, 1);

        // 5: reset mid-run at cnt=40
        steps(8);
        rst_n = 1'b0; step();
        check_eq("t5_tick", tick, 0);
        check_eq("t5_sq", sq, 0);
        check_eq("t5_done", done, 0);
        check_eq("t5_div", div, 165);
        rst_n = 1'b1; step();
        check_eq("t5_load_div", div, 49);
        wait_tick(80, n);
        check_eq("t5_gap", n, 49);

        // 6: table entries 0 and 1 -> tick every cycle; En=0 clears
        sel2 = 3'd0; en2 = 1'b1; step();
        check_eq("t6_load_tick", tick2, 0);
        check_eq("t6_div0", div2, 1);
        step();
        check_eq("t6_tick1", tick2, 1);
        check_eq("t6_sq1", sq2, 1);
        sel2 = 3'd1; step();
        check_eq("t6_tick2", tick2, 1);
        check_eq("t6_sq2", sq2, 0);
        step();
        check_eq("t6_tick3", tick2, 1);
        check_eq("t6_sq3", sq2, 1);
        check_eq("t6_div1", div2, 1);
        en2 = 1'b0; step();
        check_eq("t6_off_tick", tick2, 0);
        check_eq("t6_off_sq", sq2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
